cmp_branch_unit: RTL
====================

# cmp_branch_unit

Flag register, branch resolver and program counter for the 8-bit datapath. It sits directly downstream of the 8-bit magnitude comparator. It latches the comparator's EQ/LT/GT outputs on compare instructions and evaluates conditional branches against the held flags, or against forwarded flags when a compare and a branch arrive together. It owns the 8-bit PC and drives a pipeline flush after every taken branch.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- FLUSH_CYCLES, 1, number of flush cycles after a taken branch; legal range 1..3
- CLK  in  1  single clock; all state updates on the rising edge
- RST_N  in  1  reset, synchronous, active-low
- EQ, LT, GT  in  1 each  comparator result for the current compare
- FLAG_WE  in  1  compare instruction; latch EQ/LT/GT this cycle
- BR_VALID  in  1  branch instruction present this cycle
- BR_COND  in  3  branch condition code
- BR_TARGET  in  8  absolute branch target
- STALL  in  1  freeze PC, flags, state and counter
- PC  out  8  current fetch address
- FLAGS  out  3  latched flags, packed {GT,LT,EQ}
- TAKEN  out  1  one-cycle pulse; a branch was taken at the previous edge
- FLUSH  out  1  high while the wrong-path instruction must be squashed
- ERR  out  1  sticky; a latched flag set was not one-hot

## Operation
- Reset (RST_N=0 at an edge) overrides everything:
  - PC=RESET_PC, FLAGS=3'b000, TAKEN=0, FLUSH=0, ERR=0
  - state=RUN, flush counter=0
- States:
  - RUN: normal operation.
  - FLUSH: counter loaded with FLUSH_CYCLES-1, counts down; returns to RUN after the edge at which the counter is 0 and STALL=0.
- RUN with STALL=1: all registers hold; TAKEN=0; FLAG_WE and BR_VALID are ignored.
- RUN with STALL=0:
  - FLAG_WE=1: FLAGS <= {GT,LT,EQ}; ERR <= 1 if {GT,LT,EQ} is not one-hot. The value is latched regardless.
  - BR_VALID=1: the condition uses effective flags. These are the incoming {GT,LT,EQ} if FLAG_WE=1 in the same cycle (forwarding); otherwise the latched FLAGS.
  - Condition codes:
    - 000 always
    - 001 EQ
    - 010 !EQ
    - 011 LT
    - 100 GT
    - 101 LT|EQ
    - 110 GT|EQ
    - 111 never
  - Taken: PC <= BR_TARGET; TAKEN <= 1; state <= FLUSH.
  - Not taken, or no branch: PC <= PC+1, modulo 256 (8'hFF wraps to 8'h00).
- FLUSH with STALL=0:
  - PC <= PC+1 with wrap.
  - FLAG_WE, BR_VALID and all inputs on them are ignored (squashed); FLAGS and ERR hold.
  - Counter decrements.
- FLUSH with STALL=1: everything holds, including the counter.
- FLUSH output = (state==FLUSH).
- TAKEN is high only in the first cycle after the taking edge, even if STALL is asserted then.

## Timing
- Branch or compare sampled at edge k; results visible after edge k (one-cycle latency):
  - PC=target
  - TAKEN=1 for exactly one cycle
  - FLUSH=1 for FLUSH_CYCLES unstalled cycles, extended by any stall cycles
- First branch accepted at edge k+FLUSH_CYCLES+1 at the earliest (no stalls).
- PC is registered; no combinational path from any input to any output.
- A reset during FLUSH returns to RUN immediately, with FLUSH=0 after that edge.
- Branch to the current PC value is legal: PC is reloaded and FLUSH still occurs.

## Test plan
- Reset, then 3 idle cycles with RST_N=1 -> PC=00,01,02,03; FLAGS=000; TAKEN=0; FLUSH=0; ERR=0.
- FLAG_WE with EQ=1 at PC=05, then BR_VALID COND=001 TARGET=8'h40 on the next cycle -> PC=40, TAKEN pulses 1 cycle, FLUSH=1 for 1 cycle, then PC=41 with FLUSH=0.
- Same cycle: FLAG_WE with LT=1 (latched FLAGS=100) and BR_VALID COND=011 TARGET=8'h10 -> forwarded flags used, branch taken, FLAGS=3'b010.
- PC at 8'hFE, no branches -> PC=FF then 00. COND=111 TARGET=20 -> not taken, PC increments, TAKEN=0.
- FLUSH_CYCLES=2: taken branch, STALL=1 for 1 cycle in FLUSH, BR_VALID COND=000 asserted throughout -> FLUSH high 3 cycles, branches ignored, PC holds during the stall, TAKEN high only the first cycle.
- FLAG_WE with GT=LT=1 -> ERR=1 and stays 1 through further valid compares. RST_N=0 mid-FLUSH -> PC=RESET_PC, ERR=0, FLUSH=0 next cycle.

Source files
------------

// File: rtl/cmp_branch_if.sv
// cmp_branch_if: compare/branch bus between the decoder (master) and cmp_branch_unit (slave).
//   eq, lt, gt : comparator result for the current compare
//   flag_we    : compare instruction, latch eq/lt/gt
//   br_valid   : branch instruction present
//   br_cond    : branch condition code
//   br_target  : absolute branch target
//   stall      : freeze the unit
//   pc         : current fetch address
//   flags      : latched flags {gt,lt,eq}
//   taken      : one-cycle pulse after a taken branch
//   flush      : squash the wrong-path instruction
//   err        : sticky, a latched flag set was not one-hot
interface cmp_branch_if;
    logic       eq;
    logic       lt;
    logic       gt;
    logic       flag_we;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [7:0] br_target;
    logic       stall;
    logic [7:0] pc;
    logic [2:0] flags;
    logic       taken;
    logic       flush;
    logic       err;
    modport master (
        output eq, lt, gt, flag_we, br_valid, br_cond, br_target, stall,
        input  pc, flags, taken, flush, err
    );
    modport slave (
        input  eq, lt, gt, flag_we, br_valid, br_cond, br_target, stall,
        output pc, flags, taken, flush, err
    );
endinterface

// File: rtl/cmp_branch_unit.sv
// cmp_branch_unit: flag register, branch resolver and program counter with post-branch flush.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : cmp_branch_if slave (compare/branch inputs, pc/flags/taken/flush/err outputs)
module cmp_branch_unit #(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter int         FLUSH_CYCLES = 1
) (
    input logic         clk,
    input logic         rst_n,
    cmp_branch_if.slave bus
);
    typedef enum logic {RUN, FLSH} state_t;
    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [7:0] pc, pc_n;
    logic [2:0] flags, flags_n;
    logic       taken, taken_n;
    logic       err, err_n;
    logic [2:0] cur, eff;
    logic       one_hot, take;
    assign cur     = {bus.gt, bus.lt, bus.eq};
    // a compare in the same cycle forwards its result to the branch
    assign eff     = bus.flag_we ? cur : flags;
    assign one_hot = (cur == 3'b001) || (cur == 3'b010) || (cur == 3'b100);
    assign take    = bus.br_cond == 3'd0 ? 1'b1 :
                     bus.br_cond == 3'd1 ? eff[0] :
                     bus.br_cond == 3'd2 ? !eff[0] :
                     bus.br_cond == 3'd3 ? eff[1] :
                     bus.br_cond == 3'd4 ? eff[2] :
                     bus.br_cond == 3'd5 ? eff[1] | eff[0] :
                     bus.br_cond == 3'd6 ? eff[2] | eff[0] : 1'b0;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = pc;
        flags_n = flags;
        err_n   = err;
        taken_n = 1'b0;
        if (!bus.stall) begin
            pc_n = pc + 8'd1;
            if (state == RUN) begin
                if (bus.flag_we) begin
                    flags_n = cur;
                    err_n   = err | !one_hot;
                end
                if (bus.br_valid && take) begin
                    pc_n    = bus.br_target;
                    taken_n = 1'b1;
                    state_n = FLSH;
                    cnt_n   = 2'(FLUSH_CYCLES - 1);
                end
            end else begin
                state_n = cnt == 2'd0 ? RUN : FLSH;
                cnt_n   = cnt == 2'd0 ? cnt : cnt - 2'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
            pc    <= RESET_PC;
            flags <= 3'b000;
            taken <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pc    <= pc_n;
            flags <= flags_n;
            taken <= taken_n;
            err   <= err_n;
        end
    end
    assign bus.pc    = pc;
    assign bus.flags = flags;
    assign bus.taken = taken;
    assign bus.flush = state == FLSH;
    assign bus.err   = err;
endmodule
